// File: rtl/eth_pkg.sv
// Shared Ethernet transmit definitions: frame constants and the
// transmit-arbiter state encoding.
package eth_pkg;

  localparam int          ETH_ALEN       = 48;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          IFG_BYTES      = 12;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_arb_state_t;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Bundle between the protocol encoders, the transmit arbiter and mac_encode.
// slave = arbiter view, master = the encoders plus mac_encode around it.
interface eth_tx_arbiter_if
  import eth_pkg::*;
#(
  parameter int N = 2
);

  logic [N-1:0]          req;
  logic [N*ETH_ALEN-1:0] req_dest;
  logic [N*16-1:0]       req_ethertype;
  logic [N-1:0]          src_valid;
  logic [N*8-1:0]        src_data;
  logic [N-1:0]          src_last;
  logic [N-1:0]          src_ready;
  logic [N-1:0]          grant;
  logic                  busy;
  logic                  mac_en;
  logic [ETH_ALEN-1:0]   mac_dest;
  logic [15:0]           mac_ethertype;
  logic [7:0]            mac_payload;
  logic                  mac_send_next;
  logic                  underrun;

  modport slave (
    input  req, req_dest, req_ethertype, src_valid, src_data, src_last, mac_send_next,
    output src_ready, grant, busy, mac_en, mac_dest, mac_ethertype, mac_payload, underrun
  );

  modport master (
    output req, req_dest, req_ethertype, src_valid, src_data, src_last, mac_send_next,
    input  src_ready, grant, busy, mac_en, mac_dest, mac_ethertype, mac_payload, underrun
  );

endinterface

// File: rtl/eth_tx_arbiter_rr.sv
// Combinational round-robin pick: the first requester found scanning
// upward from ptr_i+1 with wrap-around.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_req_o
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    // Walk the scan order backwards so the nearest requester is written last.
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) winner_o = IDX_W'((int'(ptr_i) + k) % N);
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the mac_encode transmit path between N frame sources: round-robin
// grant, header latch, payload forwarding on send_next, then inter-frame gap.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N          = 2,
  parameter int IFG_CYCLES = IFG_BYTES,
  parameter int IDX_W      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  eth_tx_arbiter_if.slave bus
);

  localparam int              CNT_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  tx_arb_state_t       state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic                mac_en_q, mac_en_d;
  logic [ETH_ALEN-1:0] dest_q, dest_d;
  logic [15:0]         etype_q, etype_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic                own_valid;
  logic                own_last;
  logic [7:0]          own_data;
  logic                own_accept;

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // ptr_q doubles as the owner index for the whole frame.
  assign own_valid  = bus.src_valid[ptr_q];
  assign own_last   = bus.src_last[ptr_q];
  assign own_data   = bus.src_data[8*ptr_q +: 8];
  assign own_accept = (state_q == SEND) && bus.mac_send_next && own_valid;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      mac_en_q <= 1'b0;
      dest_q   <= '0;
      etype_q  <= '0;
      ptr_q    <= IDX_W'(N - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      mac_en_q <= mac_en_d;
      dest_q   <= dest_d;
      etype_q  <= etype_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    mac_en_d = mac_en_q;
    dest_d   = dest_q;
    etype_d  = etype_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          dest_d          = bus.req_dest[ETH_ALEN*winner +: ETH_ALEN];
          etype_d         = bus.req_ethertype[16*winner +: 16];
          mac_en_d        = 1'b1;
          ptr_d           = winner;
          state_d         = SEND;
        end
      end
      SEND: begin
        if (own_accept && own_last) begin
          grant_d  = '0;
          mac_en_d = 1'b0;
          cnt_d    = CNT_LOAD;
          state_d  = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        // Requests are deliberately not looked at until the gap has run out.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.src_ready   = '0;
    bus.mac_payload = '0;
    bus.underrun    = 1'b0;
    if (state_q == SEND) begin
      if (own_accept) begin
        bus.src_ready[ptr_q] = 1'b1;
        bus.mac_payload      = own_data;
      end
      bus.underrun = bus.mac_send_next && !own_valid;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.grant         = grant_q;
  assign bus.mac_en        = mac_en_q;
  assign bus.mac_dest      = dest_q;
  assign bus.mac_ethertype = etype_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomised scoreboard bench for eth_tx_arbiter: a cycle-level reference of
// grant/gap timing plus per-source expected payload queues.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int N   = 3;
  localparam int IFG = IFG_BYTES;

  typedef struct packed { logic [7:0] d; logic l; } sb_t;
  typedef struct packed { logic [ETH_ALEN-1:0] dest; logic [15:0] et; } hdr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_arbiter_if #(.N(N)) bus ();

  eth_tx_arbiter #(
    .N          (N),
    .IFG_CYCLES (IFG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Source-side stimulus queues (driver) and expected payload (scoreboard).
  sb_t        src_q[N][$];
  hdr_t       hdr_q[N][$];
  logic [7:0] exp_q[N][$];
  int         pend[N];
  bit         acc_flag[N];
  bit         gnt_flag[N];

  // Reference model: 0 idle, 1 sending, 2 gap. m_last is the last winner.
  int                  m_state, m_w, m_last, m_gap;
  logic [ETH_ALEN-1:0] m_dest;
  logic [15:0]         m_et;
  int                  underrun_seen = 0;
  int                  acc_cnt = 0;
  int                  grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_w = 0; m_last = N - 1; m_gap = 0; m_dest = '0; m_et = '0;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      acc_flag[i] = 1'b0;
      gnt_flag[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] eg, er;
    logic [7:0]   ep;
    bit           acc, und;
    eg = '0; er = '0; ep = '0; acc = 1'b0; und = 1'b0;
    if (m_state == 1) begin
      eg[m_w] = 1'b1;
      acc = bus.mac_send_next && bus.src_valid[m_w];
      und = bus.mac_send_next && !bus.src_valid[m_w];
      if (acc) begin
        er[m_w] = 1'b1;
        if (exp_q[m_w].size() == 0) check("sb_empty", 1, 0);
        else ep = exp_q[m_w].pop_front();
      end
    end
    check("busy", bus.busy, m_state != 0);
    check("grant", bus.grant, eg);
    check("mac_en", bus.mac_en, m_state == 1);
    check("src_ready", bus.src_ready, er);
    check("mac_payload", bus.mac_payload, ep);
    check("underrun", bus.underrun, und);
    check("mac_dest", bus.mac_dest, m_dest);
    check("mac_ethertype", bus.mac_ethertype, m_et);
    if (bus.underrun) underrun_seen++;
    case (m_state)
      0: if (bus.req != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && bus.req[(m_last + k) % N]) w = (m_last + k) % N;
        m_w = w; m_last = w; m_state = 1;
        m_dest = bus.req_dest[ETH_ALEN*w +: ETH_ALEN];
        m_et   = bus.req_ethertype[16*w +: 16];
        gnt_flag[w] = 1'b1;
        grant_log.push_back(w);
      end
      1: if (acc) begin
        acc_flag[m_w] = 1'b1;
        acc_cnt++;
        if (bus.src_last[m_w]) begin
          if (IFG == 0) m_state = 0;
          else begin m_state = 2; m_gap = IFG; end
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_state = 0;
      end
    endcase
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mac_en", bus.mac_en, 0);
        check("rst_mac_dest", bus.mac_dest, 0);
        check("rst_underrun", bus.underrun, 0);
        model_reset();
      end else begin
        model_step();
      end
    end
  end

  task automatic drive(input int vp, input int sp);
    for (int i = 0; i < N; i++) begin
      bus.req[i] = pend[i] > 0;
      if (pend[i] > 0) begin
        bus.req_dest[ETH_ALEN*i +: ETH_ALEN] = hdr_q[i][0].dest;
        bus.req_ethertype[16*i +: 16]        = hdr_q[i][0].et;
      end else begin
        bus.req_dest[ETH_ALEN*i +: ETH_ALEN] = {16'($urandom), $urandom};
        bus.req_ethertype[16*i +: 16]        = 16'($urandom);
      end
      bus.src_valid[i] = (src_q[i].size() > 0) && ($urandom_range(0, 99) < vp);
      if (bus.src_valid[i]) begin
        bus.src_data[8*i +: 8] = src_q[i][0].d;
        bus.src_last[i]        = src_q[i][0].l;
      end else begin
        bus.src_data[8*i +: 8] = 8'($urandom);
        bus.src_last[i]        = 1'($urandom);
      end
    end
    bus.mac_send_next = ($urandom_range(0, 99) < sp);
  endtask

  task automatic step(input int vp, input int sp);
    sb_t  sb;
    hdr_t h;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (acc_flag[i]) begin
          if (src_q[i].size() > 0) sb = src_q[i].pop_front();
          acc_flag[i] = 1'b0;
        end
        if (gnt_flag[i]) begin
          pend[i]--;
          if (hdr_q[i].size() > 0) h = hdr_q[i].pop_front();
          gnt_flag[i] = 1'b0;
        end
      end
    end
    drive(vp, sp);
  endtask

  task automatic enq(input int i, input logic [ETH_ALEN-1:0] d, input logic [15:0] e,
                     input int len, input logic [31:0] pat, input bit use_pat);
    hdr_t h;
    sb_t  b;
    h.dest = d;
    h.et   = e;
    hdr_q[i].push_back(h);
    pend[i]++;
    for (int k = 0; k < len; k++) begin
      b.d = use_pat ? pat[31-8*k -: 8] : 8'($urandom);
      b.l = (k == len - 1);
      src_q[i].push_back(b);
      exp_q[i].push_back(b.d);
    end
  endtask

  function automatic bit work_left();
    bit w;
    w = (m_state != 0);
    for (int i = 0; i < N; i++) w |= (pend[i] > 0) || (src_q[i].size() > 0);
    return w;
  endfunction

  task automatic run_until_idle(input int vp, input int sp, input int budget);
    int n;
    n = 0;
    while (work_left() && n < budget) begin
      step(vp, sp);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic wait_send(input int budget);
    int n;
    n = 0;
    while (m_state != 1 && n < budget) begin
      step(100, 100);
      n++;
    end
    check("wait_send", m_state, 1);
  endtask

  task automatic toggle_frame(input int budget);
    int n;
    n = 0;
    while (work_left() && n < budget) begin
      step(100, (n % 2 == 0) ? 100 : 0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL toggle_timeout: still busy after %0d cycles", n);
    end
  endtask

  initial begin
    int a0, u0;
    bus.req = '0; bus.req_dest = '0; bus.req_ethertype = '0;
    bus.src_valid = '0; bus.src_data = '0; bus.src_last = '0; bus.mac_send_next = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous requesters from reset: 0 first, then strict alternation.
    grant_log.delete();
    enq(0, 48'h0A0000000001, ETHERTYPE_IPV4, 3, 0, 0);
    enq(1, 48'h0B0000000001, ETHERTYPE_ARP, 4, 0, 0);
    enq(0, 48'h0A0000000002, ETHERTYPE_IPV4, 5, 0, 0);
    enq(1, 48'h0B0000000002, ETHERTYPE_ARP, 2, 0, 0);
    run_until_idle(100, 100, 400);
    check("alt_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("alt_g0", grant_log[0], 0);
      check("alt_g1", grant_log[1], 1);
      check("alt_g2", grant_log[2], 0);
      check("alt_g3", grant_log[3], 1);
    end

    // Single ARP frame AA BB CC DD with send_next every cycle.
    enq(0, 48'h001122334455, ETHERTYPE_ARP, 4, 32'hAABBCCDD, 1);
    run_until_idle(100, 100, 200);

    // Owner starves for two cycles while mac_encode keeps asking.
    enq(1, 48'h665544332211, ETHERTYPE_IPV4, 6, 0, 0);
    wait_send(40);
    u0 = underrun_seen;
    step(0, 100);
    step(0, 100);
    step(100, 100);
    check("underrun_pulses", underrun_seen - u0, 2);
    run_until_idle(100, 100, 200);

    // send_next toggling: one byte per high cycle.
    a0 = acc_cnt;
    enq(2, 48'h0C0000000001, ETHERTYPE_IPV4, 8, 0, 0);
    toggle_frame(200);
    check("toggle_bytes", acc_cnt - a0, 8);

    // Randomised traffic over all sources.
    for (int f = 0; f < 40; f++) begin
      enq($urandom_range(0, N - 1), {16'($urandom), $urandom}, 16'($urandom),
          $urandom_range(1, 8), 0, 0);
      repeat ($urandom_range(0, 6)) step(80, 70);
    end
    run_until_idle(80, 70, 5000);

    // Asynchronous reset between edges in the middle of a frame.
    enq(0, 48'h0D0000000001, ETHERTYPE_ARP, 10, 0, 0);
    wait_send(40);
    step(100, 100);
    #2 rst = 1'b1;
    #1;
    check("async_grant", bus.grant, 0);
    check("async_mac_en", bus.mac_en, 0);
    check("async_busy", bus.busy, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); hdr_q[i].delete(); exp_q[i].delete();
      pend[i] = 0; acc_flag[i] = 1'b0; gnt_flag[i] = 1'b0;
    end
    step(100, 100);
    step(100, 100);
    rst = 1'b0;
    enq(1, 48'h0E0000000001, ETHERTYPE_IPV4, 3, 0, 0);
    step(100, 100);
    step(100, 100);
    check("post_rst_grant", bus.grant, 3'b010);
    run_until_idle(100, 100, 200);

    repeat (3) step(100, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Shares the single mac_encode transmit datapath between N frame sources (e.g. ARP reply encoder, IP/ICMP encoder). Arbitrates round-robin and latches the winner's destination MAC and ethertype. It then sequences mac_encode's enable and forwards the winner's payload bytes on the send_next handshake. After each frame it enforces an inter-frame gap before the next grant. Sits between the protocol encoders and mac_encode in the mac top level, on clk.

Parameters:
N, 2, number of requesters (2..8)
IFG_CYCLES, 12, idle clk cycles enforced after the last payload byte before the next grant
IDX_W, $clog2(N), width of the requester index

Ports:
clk  in  1  transmit clock
rst  in  1  reset
req  in  N  per-source frame request, level, held until granted
req_dest  in  N*48  per-source destination MAC, slice i = [48*i +: 48]
req_ethertype  in  N*16  per-source ethertype, slice i = [16*i +: 16]
src_valid  in  N  per-source payload byte valid
src_data  in  N*8  per-source payload byte
src_last  in  N  marks the final payload byte of a frame
src_ready  out  N  byte accepted; one-hot or zero
grant  out  N  one-hot current owner; zero when idle or in gap
busy  out  1  high in any state other than IDLE
mac_en  out  1  to mac_encode en
mac_dest  out  48  to mac_encode mac_dest, latched
mac_ethertype  out  16  to mac_encode ethertype, latched
mac_payload  out  8  to mac_encode mac_payload, combinational
mac_send_next  in  1  from mac_encode send_next
underrun  out  1  1-cycle pulse: send_next high while the owner's src_valid is low

Interface: one clock, clk. Reset rst is asynchronous and active-high.

Behaviour:
- Reset values: state IDLE, grant 0, mac_en 0, mac_dest 0, mac_ethertype 0, underrun 0, rr pointer = N-1 (source 0 wins first), gap counter 0.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req bit is set, select the winner by round-robin: scan from (ptr+1) mod N upward with wrap-around.
  - On the next edge: grant <= onehot(winner), mac_dest/mac_ethertype <= the winner's slices, mac_en <= 1, ptr <= winner, state <= SEND.
  - Latency: req seen at edge t gives grant and mac_en at t+1.
- SEND:
  - mac_en held 1. Combinational path: src_ready[w] = mac_send_next & src_valid[w]. mac_payload = src_data[w] when src_ready[w], else 0. Other sources' ready = 0.
  - If mac_send_next & !src_valid[w]: underrun pulses for 1 cycle, no byte is consumed, the frame continues.
  - On the edge where src_ready[w] & src_last[w]: mac_en <= 0, grant <= 0, counter <= IFG_CYCLES-1, state <= GAP.
- GAP:
  - Counter decrements each cycle. At 0, state <= IDLE.
  - req is ignored in GAP. If IFG_CYCLES = 0, go directly to IDLE after SEND.
- Simultaneous requests: only one grant; the losers stay pending and are served in rotation. A held single requester is re-granted only after GAP.
- req deasserted by the owner mid-SEND is ignored. The frame ends only on src_last.
- src_last without src_valid is ignored.
- req/src signals of non-owners have no effect during SEND.
- Async reset mid-frame: everything returns to reset values immediately. mac_en drops, so mac_encode aborts.
- mac_dest/mac_ethertype are stable from grant until the next grant.

Decomposition:
- Shared package eth_pkg: localparams ETH_ALEN=48, ETHERTYPE_ARP=16'h0806, ETHERTYPE_IPV4=16'h0800, IFG_BYTES=12, and the tx_arb_state_t enum {IDLE, SEND, GAP}.
- Sub-module rr_arbiter (N, IDX_W): combinational round-robin pick from req and ptr. Outputs winner index and any_req.

Test Plan:
- Single source 0 with dest 48'h001122334455, ethertype 16'h0806, 4-byte payload AA BB CC DD (last on DD), send_next every cycle -> grant=01 and mac_en=1 one cycle after req. mac_payload sequence AA,BB,CC,DD. mac_en drops after DD. busy stays high for 12 further cycles.
- req=2'b11 from reset -> source 0 served first, then source 1 after exactly IFG_CYCLES gap cycles. With both held, grants alternate 0,1,0,1 over 4 frames.
- Owner's src_valid low for 2 cycles while send_next high -> underrun pulses on both cycles, mac_payload=0, no src_ready, and the payload order is preserved afterwards.
- mac_send_next toggling 1010 with src_valid constant -> exactly one byte consumed per send_next high. mac_payload is 0 when send_next is low.
- Assert rst asynchronously mid-SEND (between edges) -> grant, mac_en and busy go to 0 before the next edge. After release, req=2'b10 gives grant=2'b10 one cycle later.
- Source 1 changes req_dest after grant -> mac_dest holds the value latched at grant until the frame ends.
